// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: fetch PC, single-outstanding imem req/ack port, instruction buffer
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jump_addr,
    input  logic [31:0] trap_addr,
    input  logic        inst_rd_en,
    input  logic        if_id_clk_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] inst_if,
    output logic [31:0] pc_if,
    output logic        fault_if,
    output logic        inst_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] TRAP     = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state;
    logic [31:0]    fetch_pc;
    logic [31:0]    buf_pc    [FIFO_DEPTH];
    logic [31:0]    buf_inst  [FIFO_DEPTH];
    logic           buf_fault [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    logic           redirect;
    logic [31:0]    target;
    logic           ack_ok;
    logic           busy_after;
    logic           push;
    logic           pop;
    logic           issue_seq;
    logic           issue_redir;

    // Any non-sequential pc_sel is a redirect; TRAP selects trap_addr, everything else jump_addr
    assign redirect    = (pc_sel != PC_PLUS4);
    assign target      = ((pc_sel == TRAP) ? trap_addr : jump_addr) & ~32'h3;
    // An ack is only meaningful while a request is outstanding
    assign ack_ok      = imem_ack && imem_req;
    // A request is still in flight after this edge unless it completes now
    assign busy_after  = (state != S_IDLE) && !ack_ok;
    assign push        = (state == S_WAIT) && ack_ok && !redirect;
    assign pop         = if_id_clk_en && inst_ready;
    // Sequential issue: IDLE has no outstanding request, so the credit test reduces to count
    assign issue_seq   = (state == S_IDLE) && inst_rd_en && !redirect && (count < DEPTH_C);
    // A redirect flushes the buffer, so the target can be issued straight away if the port is free
    assign issue_redir = redirect && inst_rd_en && !busy_after;

    assign inst_ready = (count != '0);
    assign inst_if    = inst_ready ? buf_inst[rd_ptr]  : NOP_INST;
    assign pc_if      = inst_ready ? buf_pc[rd_ptr]    : fetch_pc;
    assign fault_if   = inst_ready ? buf_fault[rd_ptr] : 1'b0;

    // Buffer pointers and occupancy; a flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clk_en) begin
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    // Buffer payload; gated by count on the read side so it needs no reset
    always_ff @(posedge clk) begin
        if (clk_en && push) begin
            buf_pc[wr_ptr]    <= imem_addr;
            buf_inst[wr_ptr]  <= imem_rdata;
            buf_fault[wr_ptr] <= imem_err;
        end
    end

    // Fetch FSM: owns fetch_pc and the registered request port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else if (clk_en) begin
            if (issue_redir) begin
                state     <= S_WAIT;
                imem_req  <= 1'b1;
                imem_addr <= target;
                fetch_pc  <= target + 32'd4;
            end else if (redirect) begin
                fetch_pc <= target;
                if (busy_after) begin
                    state <= S_DRAIN;
                end else begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (issue_seq) begin
                            state     <= S_WAIT;
                            imem_req  <= 1'b1;
                            imem_addr <= fetch_pc;
                            fetch_pc  <= fetch_pc + 32'd4;
                        end
                    end
                    S_WAIT, S_DRAIN: begin
                        if (ack_ok) begin
                            state    <= S_IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a latency-programmable imem model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [1:0]  pc_sel;
    logic [31:0] jump_addr;
    logic [31:0] trap_addr;
    logic        inst_rd_en;
    logic        if_id_clk_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] inst_if;
    logic [31:0] pc_if;
    logic        fault_if;
    logic        inst_ready;

    fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .pc_sel       (pc_sel),
        .jump_addr    (jump_addr),
        .trap_addr    (trap_addr),
        .inst_rd_en   (inst_rd_en),
        .if_id_clk_en (if_id_clk_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .imem_err     (imem_err),
        .inst_if      (inst_if),
        .pc_if        (pc_if),
        .fault_if     (fault_if),
        .inst_ready   (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } entry_t;

    entry_t      exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    int          lat = 1;
    logic        pop_en = 1'b1;
    logic        rd_en = 1'b1;
    logic [31:0] err_addr = 32'h8;
    int          rmode = 0;
    logic [1:0]  rsel = 2'd0;
    logic [31:0] rtgt = 32'h0;
    logic        fmode = 1'b0;
    logic        fired = 1'b0;
    int          freeze_left = 0;

    logic [31:0] exp_pc = 32'h0;
    logic        req_seen = 1'b0;
    int          cnt = 0;
    logic        squashed = 1'b0;
    logic        exp_req_next = 1'b0;
    logic        prev_clk_en = 1'b1;
    logic        prev_rd_en = 1'b1;
    logic [98:0] snap = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic step();
        logic        ack;
        logic        redir;
        logic        do_pop;
        logic        ce;
        logic [98:0] cur;
        @(negedge clk);
        cur = {imem_req, imem_addr, inst_if, pc_if, fault_if, inst_ready};
        if (!prev_clk_en) check("freeze_hold", 32'(cur == snap), 32'd1);
        if (exp_req_next) begin
            check("redirect_req_latency", 32'(imem_req), 32'd1);
            exp_req_next = 1'b0;
        end
        if (!prev_rd_en) check("rd_en_blocks_issue", 32'(imem_req && !req_seen), 32'd0);
        if (imem_req && !req_seen) begin
            check("imem_addr", imem_addr, exp_pc);
            exp_pc   = exp_pc + 32'd4;
            req_seen = 1'b1;
            cnt      = 0;
        end
        check("inst_ready", 32'(inst_ready), 32'(exp_q.size() != 0));
        if (exp_q.size() == 0) begin
            check("empty_inst", inst_if, 32'h0000_0013);
            check("empty_pc", pc_if, exp_pc);
            check("empty_fault", 32'(fault_if), 32'd0);
        end

        if (fmode && imem_req && req_seen && cnt == 1 && freeze_left == 0) begin
            freeze_left = 5;
            fmode       = 1'b0;
            fired       = 1'b1;
        end
        ce = (freeze_left == 0);
        if (freeze_left > 0) freeze_left--;
        redir = 1'b0;
        if (ce && rmode != 0) begin
            if (rmode == 3 ||
                (rmode == 1 && imem_req && req_seen && cnt == 1) ||
                (rmode == 2 && imem_req && req_seen && cnt >= lat)) begin
                redir = 1'b1;
                rmode = 0;
                fired = 1'b1;
            end
        end
        ack    = ce && imem_req && req_seen && (cnt >= lat);
        do_pop = ce && pop_en && (exp_q.size() != 0);

        clk_en       = ce;
        pc_sel       = redir ? rsel : 2'd0;
        jump_addr    = rtgt;
        trap_addr    = rtgt;
        inst_rd_en   = rd_en;
        if_id_clk_en = pop_en;
        imem_ack     = ack;
        imem_rdata   = ack ? mem_data(imem_addr) : 32'h0;
        imem_err     = ack && (imem_addr == err_addr);

        if (!ce) begin
            snap = cur;
        end else begin
            if (do_pop) begin
                check("pop_pc", pc_if, exp_q[0].pc);
                check("pop_inst", inst_if, exp_q[0].inst);
                check("pop_fault", 32'(fault_if), 32'(exp_q[0].fault));
            end
            if (redir) begin
                exp_q.delete();
                exp_pc = rtgt & ~32'h3;
                if (ack) req_seen = 1'b0;
                squashed = req_seen;
                if (!req_seen && rd_en) exp_req_next = 1'b1;
            end else begin
                if (do_pop) void'(exp_q.pop_front());
                if (ack) begin
                    if (!squashed) begin
                        exp_q.push_back('{pc: imem_addr, inst: mem_data(imem_addr),
                                          fault: (imem_addr == err_addr)});
                        check("credit", 32'(exp_q.size() <= 2), 32'd1);
                    end
                    squashed = 1'b0;
                    req_seen = 1'b0;
                end
            end
            if (imem_req) cnt++;
            prev_rd_en = rd_en;
        end
        prev_clk_en = ce;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_fired(input int max_n, input string tag);
        fired = 1'b0;
        for (int i = 0; i < max_n && !fired; i++) step();
        check(tag, 32'(fired), 32'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        clk_en       = 1'b1;
        pc_sel       = 2'd0;
        jump_addr    = 32'h0;
        trap_addr    = 32'h0;
        inst_rd_en   = 1'b1;
        if_id_clk_en = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        imem_err     = 1'b0;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_inst", inst_if, 32'h0000_0013);
        check("rst_pc", pc_if, 32'h0);
        check("rst_fault", 32'(fault_if), 32'd0);
        check("rst_ready", 32'(inst_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Streaming with a 1-cycle memory; address 0x8 returns an access fault
        lat = 1; pop_en = 1'b1; rd_en = 1'b1;
        run(24);

        // IF_ID stalled: buffer fills to depth and fetch stops, then drains in order
        pop_en = 1'b0;
        run(12);
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_depth", 32'(exp_q.size()), 32'd2);
        pop_en = 1'b1;
        run(12);

        // JUMP while a 3-cycle request is pending: its response must be discarded
        lat = 3; rsel = 2'd1; rtgt = 32'h200; rmode = 1;
        run_until_fired(20, "jump_fired");
        run(20);

        // TRAP coinciding with an ack and a pop
        lat = 2; pop_en = 1'b0;
        run(6);
        pop_en = 1'b1; rsel = 2'd2; rtgt = 32'h3E8; rmode = 2;
        run_until_fired(20, "trap_fired");
        run(14);

        // Global clock enable low for 5 cycles in the middle of a request
        lat = 3; fmode = 1'b1;
        run_until_fired(20, "freeze_fired");
        run(16);

        // inst_rd_en low blocks new issues only
        lat = 2; rd_en = 1'b0;
        run(8);
        rd_en = 1'b1;
        run(8);

        // Unaligned JUMP near the top of the address space; fetch_pc wraps
        lat = 1; rsel = 2'd1; rtgt = 32'hFFFF_FFFA; rmode = 3;
        run_until_fired(2, "wrap_fired");
        run(14);

        // Asynchronous reset with a request outstanding
        fired = 1'b0;
        for (int i = 0; i < 10 && !imem_req; i++) step();
        check("req_before_reset", 32'(imem_req), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 32'd0);
        check("async_rst_ready", 32'(inst_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
